// File: rtl/alu_issue_ctrl_pkg.sv
// Shared widths, idle opcode and packed command/result records for the ALU issue controller.
package alu_pkg;

  localparam int unsigned OPW         = 4;
  localparam int unsigned RESW        = 8;
  localparam int unsigned SELW        = 4;
  localparam int unsigned ALU_LATENCY = 2;

  // Opcode that makes the ALU output zero; parked on alu_sel when no op owns the slot.
  localparam logic [SELW-1:0] SEL_IDLE = 4'b0111;

  typedef struct packed {
    logic [OPW-1:0]  a;
    logic [OPW-1:0]  b;
    logic [SELW-1:0] sel;
  } cmd_t;

  typedef struct packed {
    logic [RESW-1:0] y;
    logic [SELW-1:0] sel;
  } res_t;

endpackage

// File: rtl/alu_issue_ctrl_if.sv
// Command, ALU and result signals of the issue controller; slave is the controller side.
interface alu_issue_ctrl_if;
  import alu_pkg::*;

  logic                   in_valid;
  logic                   in_ready;
  logic signed [OPW-1:0]  in_a;
  logic signed [OPW-1:0]  in_b;
  logic        [SELW-1:0] in_sel;

  logic signed [OPW-1:0]  alu_a;
  logic signed [OPW-1:0]  alu_b;
  logic        [SELW-1:0] alu_sel;
  logic signed [RESW-1:0] alu_y;

  logic                   out_valid;
  logic                   out_ready;
  logic signed [RESW-1:0] out_y;
  logic        [SELW-1:0] out_sel;

  modport slave (
    input  in_valid, in_a, in_b, in_sel, alu_y, out_ready,
    output in_ready, alu_a, alu_b, alu_sel, out_valid, out_y, out_sel
  );

  modport master (
    output in_valid, in_a, in_b, in_sel, alu_y, out_ready,
    input  in_ready, alu_a, alu_b, alu_sel, out_valid, out_y, out_sel
  );

endinterface

// File: rtl/alu_sync_fifo.sv
// Single-clock FIFO with occupancy count; power-of-two depth so pointers wrap for free.
module alu_sync_fifo #(
  parameter int unsigned Width = 8,
  parameter int unsigned Depth = 4,
  localparam int unsigned CntW = $clog2(Depth + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [Width-1:0] wdata,
  input  logic             pop,
  output logic [Width-1:0] rdata,
  output logic [CntW-1:0]  count
);

  localparam int unsigned PtrW = $clog2(Depth);
  localparam logic [CntW-1:0] Full = CntW'(Depth);

  logic [Width-1:0] mem_q [Depth];
  logic [PtrW-1:0]  wptr_q;
  logic [PtrW-1:0]  rptr_q;
  logic [CntW-1:0]  count_q;
  logic             do_push;
  logic             do_pop;

  // A push into a full FIFO is legal only when the head leaves on the same edge.
  assign do_pop  = pop && (count_q != '0);
  assign do_push = push && ((count_q != Full) || do_pop);

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      wptr_q  <= wptr_q + PtrW'(do_push);
      rptr_q  <= rptr_q + PtrW'(do_pop);
      count_q <= count_q + CntW'(do_push) - CntW'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wptr_q] <= wdata;
    end
  end

  assign rdata = mem_q[rptr_q];
  assign count = count_q;

endmodule

// File: rtl/alu_issue_ctrl.sv
// Feeds a registered-operand ALU from a command FIFO and collects its results in order,
// issuing only when the result FIFO is guaranteed room for every op in flight.
module alu_issue_ctrl
  import alu_pkg::*;
#(
  parameter int unsigned CMD_DEPTH = 4,
  parameter int unsigned RES_DEPTH = 8
) (
  input logic              clk,
  input logic              rst,
  alu_issue_ctrl_if.slave  bus
);

  localparam int unsigned CmdCntW = $clog2(CMD_DEPTH + 1);
  localparam int unsigned ResCntW = $clog2(RES_DEPTH + 1);
  localparam int unsigned Stages  = ALU_LATENCY + 1;
  localparam logic [CmdCntW-1:0] CmdFull   = CmdCntW'(CMD_DEPTH);
  localparam logic [ResCntW:0]   ResCredit = (ResCntW + 1)'(RES_DEPTH);

  cmd_t               cmd_wdata;
  cmd_t               cmd_rdata;
  logic               cmd_push;
  logic               cmd_pop;
  logic [CmdCntW-1:0] cmd_count;
  logic               cmd_full;
  logic               cmd_empty;

  res_t               res_wdata;
  res_t               res_rdata;
  logic               res_push;
  logic               res_pop;
  logic [ResCntW-1:0] res_count;
  logic               res_empty;

  logic               issue;
  logic [ResCntW:0]   inflight;
  logic [ResCntW:0]   credit_used;

  // Stage 0: issued, 1: operands inside ALU, 2: result on alu_y.
  logic [Stages-1:0]  v_q;
  logic [SELW-1:0]    sel_q [Stages];
  logic [OPW-1:0]     alu_a_q;
  logic [OPW-1:0]     alu_b_q;
  logic [SELW-1:0]    alu_sel_q;

  // Command side
  assign cmd_full     = (cmd_count == CmdFull);
  assign cmd_empty    = (cmd_count == '0);
  assign bus.in_ready = !rst && !cmd_full;
  assign cmd_push     = bus.in_valid && bus.in_ready;

  always_comb begin
    cmd_wdata     = '0;
    cmd_wdata.a   = bus.in_a;
    cmd_wdata.b   = bus.in_b;
    cmd_wdata.sel = bus.in_sel;
  end

  alu_sync_fifo #(
    .Width($bits(cmd_t)),
    .Depth(CMD_DEPTH)
  ) u_cmd_fifo (
    .clk  (clk),
    .rst  (rst),
    .push (cmd_push),
    .wdata(cmd_wdata),
    .pop  (cmd_pop),
    .rdata(cmd_rdata),
    .count(cmd_count)
  );

  // Issue credit: every op in flight already owns a result slot, so the FIFO can never overflow.
  always_comb begin
    inflight = '0;
    for (int i = 0; i < Stages; i++) begin
      inflight = inflight + (ResCntW + 1)'(v_q[i]);
    end
    credit_used = {1'b0, res_count} + inflight;
    issue       = !cmd_empty && (credit_used < ResCredit);
  end

  assign cmd_pop = issue;

  always_ff @(posedge clk) begin
    if (rst) begin
      v_q       <= '0;
      alu_a_q   <= '0;
      alu_b_q   <= '0;
      alu_sel_q <= SEL_IDLE;
    end else begin
      v_q <= {v_q[Stages-2:0], issue};
      if (issue) begin
        alu_a_q <= cmd_rdata.a;
        alu_b_q <= cmd_rdata.b;
      end
      // The ALU registers a/b but not sel, so sel trails the operands by one edge.
      alu_sel_q <= v_q[0] ? sel_q[0] : SEL_IDLE;
    end
  end

  always_ff @(posedge clk) begin
    sel_q[0] <= cmd_rdata.sel;
    for (int i = 1; i < Stages; i++) begin
      sel_q[i] <= sel_q[i-1];
    end
  end

  assign bus.alu_a   = alu_a_q;
  assign bus.alu_b   = alu_b_q;
  assign bus.alu_sel = alu_sel_q;

  // Result side
  assign res_push = v_q[Stages-1];

  always_comb begin
    res_wdata     = '0;
    res_wdata.y   = bus.alu_y;
    res_wdata.sel = sel_q[Stages-1];
  end

  alu_sync_fifo #(
    .Width($bits(res_t)),
    .Depth(RES_DEPTH)
  ) u_res_fifo (
    .clk  (clk),
    .rst  (rst),
    .push (res_push),
    .wdata(res_wdata),
    .pop  (res_pop),
    .rdata(res_rdata),
    .count(res_count)
  );

  assign res_empty     = (res_count == '0);
  assign bus.out_valid = !rst && !res_empty;
  assign res_pop       = bus.out_valid && bus.out_ready;
  assign bus.out_y     = res_rdata.y;
  assign bus.out_sel   = res_rdata.sel;

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Directed and randomised bench for alu_issue_ctrl driving a behavioural registered-operand ALU.
module tb_alu_issue_ctrl;
  import alu_pkg::*;

  localparam int unsigned CmdDepth = 4;
  localparam int unsigned ResDepth = 8;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  alu_issue_ctrl_if bus ();

  alu_issue_ctrl #(
    .CMD_DEPTH(CmdDepth),
    .RES_DEPTH(ResDepth)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  function automatic logic [7:0] alu_f(input logic [3:0] a, input logic [3:0] b,
                                       input logic [3:0] sel);
    logic [7:0] sa;
    logic [7:0] sb;
    sa = {{4{a[3]}}, a};
    sb = {{4{b[3]}}, b};
    case (sel)
      4'b0000: return sa + 8'd1;
      4'b0001: return sa - sb;
      4'b0010: return sa & sb;
      4'b0011: return sa | sb;
      4'b0100: return sa ^ sb;
      4'b0101: return sa * sb;
      4'b0110: return sa + sb;
      4'b0111: return 8'h00;
      4'b1000: return ~sa;
      default: return sa - sb;
    endcase
  endfunction

  // ALU: operands registered, sel used combinationally, result registered.
  logic [3:0] ra;
  logic [3:0] rb;
  always @(posedge clk) begin
    ra        <= bus.alu_a;
    rb        <= bus.alu_b;
    bus.alu_y <= alu_f(ra, rb, bus.alu_sel);
  end

  int n_assert = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int n_acc    = 0;
  int n_pop    = 0;
  int acc_cyc  = 0;

  cmd_t       iss_q[$];
  res_t       exp_q[$];
  logic [7:0] got_y[$];
  logic [3:0] got_sel[$];
  int         got_cyc[$];
  logic [3:0] sel_tab [8] = '{4'h0, 4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'h8};

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] want);
    n_assert++;
    assert (obs === want) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, want);
    end
  endtask

  task automatic step(input logic iv, input logic [3:0] a, input logic [3:0] b,
                      input logic [3:0] sel, input logic ordy);
    cmd_t c;
    res_t r;
    logic acc;
    logic pop;
    @(negedge clk);
    if (!rst && bus.alu_sel != SEL_IDLE) begin
      if (iss_q.size() == 0) begin
        check("issue_unexpected", 32'(bus.alu_sel), 32'(SEL_IDLE));
      end else begin
        c = iss_q.pop_front();
        check("sel_follows_ops", {20'h0, bus.alu_sel, ra, rb}, {20'h0, c.sel, c.a, c.b});
      end
    end
    bus.in_valid  = iv;
    bus.in_a      = a;
    bus.in_b      = b;
    bus.in_sel    = sel;
    bus.out_ready = ordy;
    acc = iv && bus.in_ready;
    pop = bus.out_valid && ordy;
    if (acc) begin
      c.a = a;
      c.b = b;
      c.sel = sel;
      iss_q.push_back(c);
      r.y = alu_f(a, b, sel);
      r.sel = sel;
      exp_q.push_back(r);
      acc_cyc = cyc;
      n_acc++;
    end
    if (pop) begin
      got_y.push_back(bus.out_y);
      got_sel.push_back(bus.out_sel);
      got_cyc.push_back(cyc);
      n_pop++;
      if (exp_q.size() == 0) begin
        check("result_unexpected", 32'(bus.out_valid), 32'h0);
      end else begin
        r = exp_q.pop_front();
        check("result_order", {20'h0, bus.out_y, bus.out_sel}, {20'h0, r.y, r.sel});
      end
    end
    cyc++;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 4'h0, 4'h0, 4'h0, 1'b1);
  endtask

  task automatic drain(input int n, input int budget);
    int k;
    k = 0;
    while (got_y.size() < n && k < budget) begin
      step(1'b0, 4'h0, 4'h0, 4'h0, 1'b1);
      k++;
    end
    check("drain_count", 32'(got_y.size()), 32'(n));
  endtask

  task automatic clear_got();
    got_y.delete();
    got_sel.delete();
    got_cyc.delete();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    idle(2);
    check("rst_in_ready", 32'(bus.in_ready), 32'h0);
    check("rst_out_valid", 32'(bus.out_valid), 32'h0);
    check("rst_alu_sel", 32'(bus.alu_sel), 32'(SEL_IDLE));
    check("rst_alu_ops", 32'({bus.alu_a, bus.alu_b}), 32'h0);
    rst = 1'b0;
    iss_q.delete();
    exp_q.delete();
  endtask

  initial begin
    int a0;
    int base;
    int k;
    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.in_a      = '0;
    bus.in_b      = '0;
    bus.in_sel    = '0;
    bus.out_ready = 1'b0;

    do_reset();
    idle(1);
    check("post_rst_in_ready", 32'(bus.in_ready), 32'h1);
    check("post_rst_out_valid", 32'(bus.out_valid), 32'h0);

    // Single op: 3 + 5
    clear_got();
    step(1'b1, 4'h3, 4'h5, 4'b0110, 1'b1);
    a0 = acc_cyc;
    drain(1, 20);
    check("single_y", 32'(got_y[0]), 32'h08);
    check("single_sel", 32'(got_sel[0]), 32'h6);
    check("single_latency", 32'(got_cyc[0] - a0), 32'd5);

    // Back-to-back: -2*3, ~5, -1+1
    clear_got();
    step(1'b1, 4'hE, 4'h3, 4'b0101, 1'b1);
    a0 = acc_cyc;
    step(1'b1, 4'h5, 4'h3, 4'b1000, 1'b1);
    step(1'b1, 4'hF, 4'h3, 4'b0000, 1'b1);
    drain(3, 20);
    check("b2b_y0", 32'(got_y[0]), 32'hFA);
    check("b2b_y1", 32'(got_y[1]), 32'hFA);
    check("b2b_y2", 32'(got_y[2]), 32'h00);
    check("b2b_sel", 32'({got_sel[0], got_sel[1], got_sel[2]}), 32'h580);
    check("b2b_latency", 32'(got_cyc[0] - a0), 32'd5);
    check("b2b_gap01", 32'(got_cyc[1] - got_cyc[0]), 32'd1);
    check("b2b_gap12", 32'(got_cyc[2] - got_cyc[1]), 32'd1);

    // Backpressure: only the FIFO capacities worth of commands may enter
    clear_got();
    base = n_acc;
    for (int i = 0; i < 20; i++) begin
      step(1'b1, 4'(i), 4'(15 - i), sel_tab[i % 8], 1'b0);
    end
    check("bp_accepted", 32'(n_acc - base), 32'(ResDepth + CmdDepth));
    check("bp_in_ready", 32'(bus.in_ready), 32'h0);
    check("bp_out_valid", 32'(bus.out_valid), 32'h1);
    drain(ResDepth + CmdDepth, 60);
    idle(6);
    check("bp_no_dup", 32'(got_y.size()), 32'(ResDepth + CmdDepth));
    check("bp_model_empty", 32'(exp_q.size()), 32'h0);

    // Reset with three ops in flight
    clear_got();
    step(1'b1, 4'h1, 4'h2, 4'b0110, 1'b1);
    step(1'b1, 4'h3, 4'h3, 4'b0101, 1'b1);
    step(1'b1, 4'h7, 4'h1, 4'b0001, 1'b1);
    idle(1);
    base = n_pop;
    do_reset();
    idle(8);
    check("rst_no_stale", 32'(n_pop - base), 32'h0);
    check("rst_sel_idle", 32'(bus.alu_sel), 32'(SEL_IDLE));
    step(1'b1, 4'h2, 4'h3, 4'b0110, 1'b1);
    drain(1, 20);
    check("post_rst_y", 32'(got_y[0]), 32'h05);
    check("post_rst_sel", 32'(got_sel[0]), 32'h6);

    // Random valid/ready toggling against the model
    clear_got();
    base = n_acc;
    k = 0;
    while (n_acc - base < 1000 && k < 20000) begin
      step(($urandom_range(0, 3) != 0), 4'($urandom), 4'($urandom),
           sel_tab[$urandom_range(0, 7)], ($urandom_range(0, 3) != 0));
      k++;
    end
    check("rand_accepted", 32'(n_acc - base), 32'd1000);
    drain(1000, 300);
    check("rand_model_empty", 32'(exp_q.size()), 32'h0);
    check("rand_issue_empty", 32'(iss_q.size()), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
